// File: rtl/ebus_cycle_decoder_if.sv
`default_nettype none
//============================================================================
// Module      : ebus_cycle_decoder_if
// Description : Signal bundle for the Z80 expansion-bus cycle decoder.
//               Carries the asynchronous Z80 bus (address, data, strobes),
//               the decoded command side (address/data/strobes to the
//               VDP/PSG/mapper consumers) and the read-data return path.
//   slave  modport : the decoder (samples ebus_*, drives commands/read data)
//   master modport : the bus/consumer side (drives ebus_*, bus_rddata)
// Revision    : 1.0 - initial release
//============================================================================
interface ebus_cycle_decoder_if;
    // Z80 side (asynchronous to clk)
    logic [15:0] ebus_a;
    logic [7:0]  ebus_d_in;
    logic        ebus_rd_n;
    logic        ebus_wr_n;
    logic        ebus_mreq_n;
    logic        ebus_iorq_n;
    // Command side (clk domain)
    logic [15:0] bus_addr;
    logic [7:0]  bus_wrdata;
    logic        io_wr;
    logic        io_rd;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  bus_rddata;
    // Read data returned to the Z80 bus
    logic [7:0]  ebus_d_out;
    logic        ebus_d_oe;

    modport slave (
        input  ebus_a, ebus_d_in, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n,
        input  bus_rddata,
        output bus_addr, bus_wrdata, io_wr, io_rd, mem_wr, mem_rd,
        output ebus_d_out, ebus_d_oe
    );

    modport master (
        output ebus_a, ebus_d_in, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n,
        output bus_rddata,
        input  bus_addr, bus_wrdata, io_wr, io_rd, mem_wr, mem_rd,
        input  ebus_d_out, ebus_d_oe
    );
endinterface
`default_nettype wire

// File: rtl/ebus_cycle_decoder.sv
`default_nettype none
//============================================================================
// Module      : ebus_cycle_decoder
// Description : Front end of the Z80 expansion-bus path. Synchronizes the
//               async bus strobes, glitch-filters the cycle qualifiers,
//               classifies each cycle as I/O/memory read/write and emits one
//               single-cycle command strobe with latched address/write data.
//               Read data from the consumer is held on ebus_d_out with
//               ebus_d_oe while the Z80 read is still in progress.
// Ports       : clk, reset (async, active-high)
//               bus : ebus_cycle_decoder_if.slave (Z80 bus + command side)
// Parameters  : SYNC_STAGES - flops per strobe synchronizer (>= 2)
//               FILTER_LEN  - synced samples a qualifier must hold
// Revision    : 1.0 - initial release
//============================================================================
module ebus_cycle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    ebus_cycle_decoder_if.slave  bus
);

    localparam int               C_SYNC_W   = 4 * SYNC_STAGES;
    localparam int               C_CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(FILTER_LEN);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(FILTER_LEN - 1);

    // Qualifier / strobe bit positions
    localparam int C_Q_IOW = 3;
    localparam int C_Q_IOR = 2;
    localparam int C_Q_MW  = 1;
    localparam int C_Q_MR  = 0;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("ebus_cycle_decoder: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACT_WR    = 2'd2,
        ST_ACT_RD    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers: one nibble {rd_n, wr_n, mreq_n, iorq_n} per stage,
    // newest sample in the low nibble. Reset to the idle (all high) level.
    // ------------------------------------------------------------------
    logic [C_SYNC_W-1:0] r_sync;
    logic [15:0]         r_a;
    logic [7:0]          r_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
            r_a    <= '0;
            r_d    <= '0;
        end else begin
            r_sync <= {r_sync[C_SYNC_W-5:0], bus.ebus_rd_n, bus.ebus_wr_n,
                       bus.ebus_mreq_n, bus.ebus_iorq_n};
            r_a    <= bus.ebus_a;
            r_d    <= bus.ebus_d_in;
        end
    end

    logic [3:0] w_sync_last;
    logic [3:0] w_sync_ahead;
    logic       w_rd, w_wr, w_mreq, w_iorq;
    logic       w_wr_ahead;
    logic       w_all_idle;
    logic       w_invalid;
    logic       w_req_sel;
    logic [3:0] w_qual;
    logic [3:0] w_hit;

    assign w_sync_last  = r_sync[C_SYNC_W-1 -: 4];
    // Stage that becomes the synced value on the next edge; lets oe drop
    // in the same cycle that synced wr_n goes low.
    assign w_sync_ahead = r_sync[C_SYNC_W-5 -: 4];
    assign w_rd         = w_sync_last[3];
    assign w_wr         = w_sync_last[2];
    assign w_mreq       = w_sync_last[1];
    assign w_iorq       = w_sync_last[0];
    assign w_wr_ahead   = w_sync_ahead[2];
    // Every stage idle: the whole pipeline holds post-release samples.
    assign w_all_idle   = &r_sync;
    assign w_invalid    = (~w_mreq & ~w_iorq) | (~w_rd & ~w_wr);

    assign w_qual[C_Q_IOW] = ~w_iorq & ~w_wr &  w_rd;
    assign w_qual[C_Q_IOR] = ~w_iorq & ~w_rd &  w_wr;
    assign w_qual[C_Q_MW]  = ~w_mreq & ~w_wr &  w_rd;
    assign w_qual[C_Q_MR]  = ~w_mreq & ~w_rd &  w_wr;

    // ------------------------------------------------------------------
    // Glitch filter: counters saturate at FILTER_LEN, so a qualifier held
    // forever can hit the accept value (FILTER_LEN-1 -> FILTER_LEN) once.
    // ------------------------------------------------------------------
    logic [C_CNT_W-1:0] r_cnt [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_invalid || !w_qual[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != C_CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Accept on the edge where the counter reaches FILTER_LEN; qualifiers are
    // mutually exclusive once invalid combinations are excluded.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = w_qual[i] & ~w_invalid & (r_cnt[i] == C_CNT_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Cycle FSM with registered outputs
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [3:0]  r_strobe, w_strobe_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_wrdata, w_wrdata_nxt;
    logic [7:0]  r_dout, w_dout_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_sel_io, w_sel_io_nxt;
    logic        r_primed;

    // Selected request released (high) for the active cycle
    assign w_req_sel = r_sel_io ? w_iorq : w_mreq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_WAIT_IDLE;
            r_strobe <= '0;
            r_addr   <= '0;
            r_wrdata <= '0;
            r_dout   <= '0;
            r_oe     <= 1'b0;
            r_sel_io <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_strobe_nxt;
            r_addr   <= w_addr_nxt;
            r_wrdata <= w_wrdata_nxt;
            r_dout   <= w_dout_nxt;
            r_oe     <= w_oe_nxt;
            r_sel_io <= w_sel_io_nxt;
            r_primed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_strobe_nxt = '0;
        w_addr_nxt   = r_addr;
        w_wrdata_nxt = r_wrdata;
        w_dout_nxt   = r_dout;
        w_oe_nxt     = r_oe;
        w_sel_io_nxt = r_sel_io;
        case (r_state)
            ST_WAIT_IDLE: begin
                w_oe_nxt = 1'b0;
                // The synchronizers reset to idle, so the first post-reset
                // edge must not count as a bus release (r_primed).
                if (r_primed && w_all_idle) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_oe_nxt = 1'b0;
                if (|w_hit) begin
                    w_strobe_nxt = w_hit;
                    w_addr_nxt   = r_a;
                    w_wrdata_nxt = r_d;
                    w_sel_io_nxt = w_hit[C_Q_IOW] | w_hit[C_Q_IOR];
                    w_state_nxt  = (w_hit[C_Q_IOW] | w_hit[C_Q_MW]) ? ST_ACT_WR
                                                                     : ST_ACT_RD;
                end
            end
            ST_ACT_WR: begin
                if (w_wr && w_req_sel) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACT_RD: begin
                if (!w_wr_ahead) begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = ST_WAIT_IDLE;
                end else if (w_rd || w_req_sel) begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (!r_oe) begin
                    // First cycle after the read strobe
                    w_dout_nxt = bus.bus_rddata;
                    w_oe_nxt   = 1'b1;
                end
            end
            default: begin
                w_oe_nxt    = 1'b0;
                w_state_nxt = ST_WAIT_IDLE;
            end
        endcase
    end

    assign bus.io_wr      = r_strobe[C_Q_IOW];
    assign bus.io_rd      = r_strobe[C_Q_IOR];
    assign bus.mem_wr     = r_strobe[C_Q_MW];
    assign bus.mem_rd     = r_strobe[C_Q_MR];
    assign bus.bus_addr   = r_addr;
    assign bus.bus_wrdata = r_wrdata;
    assign bus.ebus_d_out = r_dout;
    assign bus.ebus_d_oe  = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_ebus_cycle_decoder.sv
`default_nettype none
`timescale 1ns/100ps
//============================================================================
// Module      : tb_ebus_cycle_decoder
// Description : Scoreboard bench for ebus_cycle_decoder. Stimulus tasks push
//               the expected command for each Z80 cycle into a queue; a
//               monitor on the falling clock edge pops and compares whenever
//               a command strobe appears, and checks read data when the
//               output enable rises.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ebus_cycle_decoder;

    localparam int C_SYNC = 2;
    localparam int C_FILT = 2;

    localparam logic [3:0] C_K_IOW = 4'b1000;
    localparam logic [3:0] C_K_IOR = 4'b0100;
    localparam logic [3:0] C_K_MW  = 4'b0010;
    localparam logic [3:0] C_K_MR  = 4'b0001;

    typedef struct {
        logic [3:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  rdd;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    ebus_cycle_decoder_if bus_if();

    ebus_cycle_decoder #(
        .SYNC_STAGES (C_SYNC),
        .FILTER_LEN  (C_FILT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ~28.6 MHz sysclk
    initial clk = 1'b0;
    always #17.5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] kind, input logic [15:0] a,
                            input logic [7:0] d, input logic [7:0] rdd);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.rdd = rdd;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic       rd_pending = 1'b0;
    logic [7:0] rd_exp     = '0;
    logic       oe_prev    = 1'b0;

    always @(negedge clk) begin
        logic [3:0] strobes;
        exp_t       e;
        strobes = {bus_if.io_wr, bus_if.io_rd, bus_if.mem_wr, bus_if.mem_rd};
        if (!reset) begin
            if (strobes != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {28'd0, strobes}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {28'd0, strobes}, {28'd0, e.kind});
                    check("bus_addr", {16'd0, bus_if.bus_addr}, {16'd0, e.addr});
                    check("bus_wrdata", {24'd0, bus_if.bus_wrdata}, {24'd0, e.data});
                    if (e.kind == C_K_IOR || e.kind == C_K_MR) begin
                        rd_pending = 1'b1;
                        rd_exp     = e.rdd;
                    end
                end
            end
            if (bus_if.ebus_d_oe && !oe_prev) begin
                check("oe_rise_pending_read", {31'd0, rd_pending}, 32'd1);
                check("ebus_d_out", {24'd0, bus_if.ebus_d_out}, {24'd0, rd_exp});
                rd_pending = 1'b0;
            end
        end
        oe_prev = bus_if.ebus_d_oe;
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (Z80 at 3.58 MHz, T ~ 279 ns)
    // ------------------------------------------------------------------
    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk); #5;
        bus_if.ebus_a = a; bus_if.ebus_d_in = d;
        #140;
        push_exp(C_K_IOW, a, d, 8'h00);
        bus_if.ebus_iorq_n = 1'b0; bus_if.ebus_wr_n = 1'b0;
        #700;
        bus_if.ebus_wr_n = 1'b1; bus_if.ebus_iorq_n = 1'b1;
        #280;
    endtask

    task automatic bus_read(input logic is_io, input logic [15:0] a, input logic [7:0] rdd);
        @(negedge clk); #5;
        bus_if.ebus_a = a; bus_if.ebus_d_in = 8'hFF; bus_if.bus_rddata = rdd;
        #140;
        push_exp(is_io ? C_K_IOR : C_K_MR, a, 8'hFF, rdd);
        if (is_io) bus_if.ebus_iorq_n = 1'b0; else bus_if.ebus_mreq_n = 1'b0;
        bus_if.ebus_rd_n = 1'b0;
        #600;
        check("oe_during_read", {31'd0, bus_if.ebus_d_oe}, 32'd1);
        check("dout_during_read", {24'd0, bus_if.ebus_d_out}, {24'd0, rdd});
        bus_if.ebus_rd_n = 1'b1; bus_if.ebus_iorq_n = 1'b1; bus_if.ebus_mreq_n = 1'b1;
        #175;
        check("oe_after_release", {31'd0, bus_if.ebus_d_oe}, 32'd0);
        check("dout_held", {24'd0, bus_if.ebus_d_out}, {24'd0, rdd});
        #140;
    endtask

    // Memory write with edge-aligned WR_n to check the exact strobe latency
    task automatic mem_write_lat(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk); #5;
        bus_if.ebus_a = a; bus_if.ebus_d_in = d;
        bus_if.ebus_mreq_n = 1'b0;
        #140;
        @(posedge clk); #1;
        push_exp(C_K_MW, a, d, 8'h00);
        bus_if.ebus_wr_n = 1'b0;
        for (int k = 1; k <= C_SYNC + C_FILT; k++) begin
            @(posedge clk); #1;
            if (k < C_SYNC + C_FILT) check("mw_early", {31'd0, bus_if.mem_wr}, 32'd0);
            else                     check("mw_latency", {31'd0, bus_if.mem_wr}, 32'd1);
        end
        @(negedge clk); #5;
        #300;
        bus_if.ebus_wr_n = 1'b1; bus_if.ebus_mreq_n = 1'b1;
        #280;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic bad;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_if.ebus_a      = '0;
        bus_if.ebus_d_in   = '0;
        bus_if.ebus_rd_n   = 1'b1;
        bus_if.ebus_wr_n   = 1'b1;
        bus_if.ebus_mreq_n = 1'b1;
        bus_if.ebus_iorq_n = 1'b1;
        bus_if.bus_rddata  = '0;
        repeat (4) @(negedge clk);
        #5 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_strobes", {28'd0, bus_if.io_wr, bus_if.io_rd, bus_if.mem_wr, bus_if.mem_rd}, 32'd0);
        check("rst_addr", {16'd0, bus_if.bus_addr}, 32'd0);
        check("rst_wrdata", {24'd0, bus_if.bus_wrdata}, 32'd0);
        check("rst_dout", {24'd0, bus_if.ebus_d_out}, 32'd0);
        check("rst_oe", {31'd0, bus_if.ebus_d_oe}, 32'd0);

        io_write(16'h00BF, 8'hC0);
        bus_read(1'b1, 16'h00BE, 8'hA5);
        mem_write_lat(16'hC100, 8'h42);
        bus_read(1'b0, 16'hE100, 8'h5A);

        // Glitch on IORQ_n with WR_n low: no strobe; then a held pulse: one io_wr
        @(negedge clk); #5;
        bus_if.ebus_a = 16'h00BF; bus_if.ebus_d_in = 8'h33;
        bus_if.ebus_wr_n = 1'b0;
        #100;
        bus_if.ebus_iorq_n = 1'b0;
        #30;
        bus_if.ebus_iorq_n = 1'b1;
        #300;
        push_exp(C_K_IOW, 16'h00BF, 8'h33, 8'h00);
        bus_if.ebus_iorq_n = 1'b0;
        #200;
        bus_if.ebus_iorq_n = 1'b1; bus_if.ebus_wr_n = 1'b1;
        #280;

        // Invalid: MREQ_n and IORQ_n both low with WR_n low for 500 ns
        @(negedge clk); #5;
        bus_if.ebus_a = 16'h1234; bus_if.ebus_d_in = 8'h77;
        bus_if.ebus_mreq_n = 1'b0; bus_if.ebus_iorq_n = 1'b0; bus_if.ebus_wr_n = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus_if.ebus_d_oe) bad = 1'b1;
        end
        check("invalid_oe_low", {31'd0, bad}, 32'd0);
        #5;
        bus_if.ebus_mreq_n = 1'b1; bus_if.ebus_iorq_n = 1'b1; bus_if.ebus_wr_n = 1'b1;
        #280;

        // Reset in the middle of an I/O read with oe already driven
        @(negedge clk); #5;
        bus_if.ebus_a = 16'h00BE; bus_if.ebus_d_in = 8'hFF; bus_if.bus_rddata = 8'h3C;
        #140;
        push_exp(C_K_IOR, 16'h00BE, 8'hFF, 8'h3C);
        bus_if.ebus_iorq_n = 1'b0; bus_if.ebus_rd_n = 1'b0;
        for (int i = 0; i < 40 && !bus_if.ebus_d_oe; i++) @(negedge clk);
        check("rst_mid_oe_before", {31'd0, bus_if.ebus_d_oe}, 32'd1);
        #7;
        reset = 1'b1;
        #1;
        check("rst_mid_oe_async", {31'd0, bus_if.ebus_d_oe}, 32'd0);
        check("rst_mid_addr", {16'd0, bus_if.bus_addr}, 32'd0);
        check("rst_mid_dout", {24'd0, bus_if.ebus_d_out}, 32'd0);
        repeat (3) @(negedge clk);
        #5 reset = 1'b0;
        #300;
        check("rst_mid_oe_after", {31'd0, bus_if.ebus_d_oe}, 32'd0);
        bus_if.ebus_rd_n = 1'b1; bus_if.ebus_iorq_n = 1'b1;
        #280;
        io_write(16'h00BF, 8'h81);

        #300;
        check("missing_strobes", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
